// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one strobed peripheral bus between two masters.
//
// Ports:
//   i_cpu_clk, i_rst_n                 clock, synchronous active-low reset
//   i_mN_req/we/addr/wdata             master N request level and transaction fields
//   o_mN_done/err/rdata                master N one-cycle completion pulse, timeout flag, read data
//   o_bus_clk/we/addr/data             one-cycle transaction strobe and latched transaction
//   i_bus_data, i_bus_data_ready       peripheral read data and completion
//   o_owner                            current or last granted master
//   o_busy                             high whenever a transaction is in flight
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_done,
    output logic              o_m0_err,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_done,
    output logic              o_m1_err,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_data_ready,
    output logic              o_owner,
    output logic              o_busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    // Leaving WAIT on this count means the counter reaches TIMEOUT as DONE is entered.
    localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            any_req;
    logic            grant;
    logic            finish;
    logic [DATA_W-1:0] result;

    always_comb begin
        any_req  = i_m0_req || i_m1_req;
        // On a tie the master that did not win last time is granted.
        grant    = (i_m0_req && i_m1_req) ? ~last : i_m1_req;
        finish   = i_bus_data_ready || (cnt == CLAST);
        result   = i_bus_data_ready ? i_bus_data : '1;
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = any_req ? ISSUE : IDLE;
            ISSUE: state_nx = WAIT;
            WAIT:  state_nx = finish ? DONE : WAIT;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_cpu_clk) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge i_cpu_clk) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            last       <= 1'b1;
            o_owner    <= 1'b0;
            o_bus_clk  <= 1'b0;
            o_bus_we   <= 1'b0;
            o_bus_addr <= '0;
            o_bus_data <= '0;
            o_m0_done  <= 1'b0;
            o_m0_err   <= 1'b0;
            o_m0_rdata <= '0;
            o_m1_done  <= 1'b0;
            o_m1_err   <= 1'b0;
            o_m1_rdata <= '0;
        end else begin
            o_bus_clk <= (state == IDLE) && any_req;
            o_m0_done <= 1'b0;
            o_m1_done <= 1'b0;
            if (state == IDLE && any_req) begin
                cnt        <= '0;
                last       <= grant;
                o_owner    <= grant;
                o_bus_we   <= grant ? i_m1_we    : i_m0_we;
                o_bus_addr <= grant ? i_m1_addr  : i_m0_addr;
                o_bus_data <= grant ? i_m1_wdata : i_m0_wdata;
            end
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (finish) begin
                    if (o_owner) begin
                        o_m1_done  <= 1'b1;
                        o_m1_err   <= !i_bus_data_ready;
                        o_m1_rdata <= result;
                    end else begin
                        o_m0_done  <= 1'b1;
                        o_m0_err   <= !i_bus_data_ready;
                        o_m0_rdata <= result;
                    end
                end
            end
        end
    end

    assign o_busy = (state != IDLE);
endmodule
